// File: rtl/ternary_layer_sched_if.sv
// Handshake bundle for ternary_layer_sched: weight load, input vector and result stream.
// The master is the I/O glue and result consumer; the slave is the scheduler.
interface ternary_layer_sched_if #(
    parameter int IDX_W = 3
);
    logic             wt_valid;
    logic             wt_first;
    logic [7:0]       wt_data;
    logic             wt_ready;
    logic             in_valid;
    logic [3:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [3:0]       out_data;
    logic             busy;

    modport master (
        output wt_valid, wt_first, wt_data, in_valid, in_data, out_ready,
        input  wt_ready, in_ready, out_valid, out_idx, out_data, busy
    );

    modport slave (
        input  wt_valid, wt_first, wt_data, in_valid, in_data, out_ready,
        output wt_ready, in_ready, out_valid, out_idx, out_data, busy
    );
endinterface

// File: rtl/ternary_layer_sched.sv
// Time-multiplexed 4-input ternary perceptron layer on one shared accumulate datapath.
// Optional macro TERN_RELU_EN clamps negative neuron sums to zero at the output register.
module ternary_layer_sched #(
    parameter int NEURONS = 4,
    parameter int IDX_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ternary_layer_sched_if.slave       bus,
    output logic [1:0]                 state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NEURONS - 1);
    localparam int               SLOTS = 2 ** IDX_W;

    state_t           state, next_state;
    logic [7:0]       wts [SLOTS];
    logic [IDX_W-1:0] wptr;
    logic [IDX_W-1:0] idx;
    logic [3:0]       vec;
    logic [3:0]       cur_sum;
    logic             load;
    logic             wt_fire;
    logic             in_fire;

    // Crumb 01 adds the input bit, 11 subtracts it, 00/10 contribute nothing.
    function automatic logic [3:0] tern_sum(input logic [7:0] w, input logic [3:0] x);
        logic [3:0] acc;
        acc = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (x[i]) begin
                if (w[2*i +: 2] == 2'b01)      acc = acc + 4'd1;
                else if (w[2*i +: 2] == 2'b11) acc = acc - 4'd1;
            end
        end
        return acc;
    endfunction

    assign cur_sum   = tern_sum(wts[idx], vec);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_fire) next_state = RUN;
            RUN:     if (load && idx == LAST) next_state = DRAIN;
            DRAIN:   if (bus.out_valid && bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // valid/ready: a transfer happens on a rising edge where both are high; the sender
    // holds valid and payload stable until then. Weights win over inputs in IDLE.
    always_comb begin
        bus.wt_ready = (state == IDLE);
        bus.in_ready = (state == IDLE) && !bus.wt_valid;
        bus.busy     = (state != IDLE);
        load         = (state == RUN) && (!bus.out_valid || bus.out_ready);
        wt_fire      = bus.wt_valid && bus.wt_ready;
        in_fire      = bus.in_valid && bus.in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) wts[i] <= 8'h00;
            wptr <= '0;
        end else if (wt_fire) begin
            if (bus.wt_first) begin
                wts[0] <= bus.wt_data;
                wptr   <= IDX_W'(1);
            end else begin
                wts[wptr] <= bus.wt_data;
                wptr      <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec           <= 4'd0;
            idx           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_data  <= 4'd0;
        end else begin
            if (in_fire) begin
                vec <= bus.in_data;
                idx <= '0;
            end
            if (load) begin
`ifdef TERN_RELU_EN
                bus.out_data <= cur_sum[3] ? 4'd0 : cur_sum;
`else
                bus.out_data <= cur_sum;
`endif
                bus.out_idx   <= idx;
                bus.out_valid <= 1'b1;
                idx           <= (idx == LAST) ? '0 : idx + 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ternary_layer_sched.sv
// Randomized self-checking bench for ternary_layer_sched against a per-neuron arithmetic model.
module tb_ternary_layer_sched;
  localparam int NEURONS = 4;
  localparam int IDX_W   = 3;
  localparam int W       = IDX_W + 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         n_cmp = 0;
  int         n_err = 0;
  int         ready_mode = 0;
  int         rpat = 0;

  ternary_layer_sched_if #(.IDX_W(IDX_W)) bus ();

  ternary_layer_sched #(.NEURONS(NEURONS), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   m_wts [NEURONS];
  int           m_wptr;
  bit           m_active;
  int           m_age;
  logic [W-1:0] exp_q[$];

  function automatic logic [3:0] ref_sum(input logic [7:0] w, input logic [3:0] x);
    int s;
    int c;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      c = (w >> (2 * i)) & 3;
      if (x[i]) s += (c == 1) ? 1 : (c == 3) ? -1 : 0;
    end
`ifdef TERN_RELU_EN
    if (s < 0) s = 0;
`endif
    return 4'(s);
  endfunction

  always @(negedge clk) begin
    bit           act;
    logic [W-1:0] e;
    if (!rst_n) begin
      for (int i = 0; i < NEURONS; i++) m_wts[i] = 8'h00;
      m_wptr   = 0;
      m_active = 0;
      m_age    = 0;
      exp_q.delete();
    end else begin
      act = m_active;
      m_age++;
      check("busy", bus.busy, act);
      check("wt_ready", bus.wt_ready, !act);
      check("in_ready", bus.in_ready, !act && !bus.wt_valid);
      check("out_valid", bus.out_valid, act && m_age >= 2);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("out_extra", 1, 0);
        else begin
          check("out_idx", bus.out_idx, exp_q[0][W-1:4]);
          check("out_data", bus.out_data, exp_q[0][3:0]);
        end
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (exp_q.size() == 0) m_active = 0;
      end
      if (bus.wt_valid && !act) begin
        if (bus.wt_first) begin
          m_wts[0] = bus.wt_data;
          m_wptr   = 1;
        end else begin
          m_wts[m_wptr] = bus.wt_data;
          m_wptr        = (m_wptr + 1) % NEURONS;
        end
      end
      if (bus.in_valid && !act && !bus.wt_valid) begin
        for (int k = 0; k < NEURONS; k++)
          exp_q.push_back({IDX_W'(k), ref_sum(m_wts[k], bus.in_data)});
        m_active = 1;
        m_age    = 0;
      end
    end
  end

  // ---------------- consumer backpressure ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       begin bus.out_ready = (rpat % 3 == 0); rpat++; end
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- drivers (enter and leave at posedge + 1) ----------------
  task automatic write_wt(input logic first, input logic [7:0] d);
    int   n;
    logic acc;
    n = 0;
    bus.wt_valid = 1'b1;
    bus.wt_first = first;
    bus.wt_data  = d;
    do begin
      @(negedge clk); acc = bus.wt_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    if (!acc) check("wt_timeout", 0, 1);
    bus.wt_valid = 1'b0;
    bus.wt_first = 1'b0;
  endtask

  task automatic send_in(input logic [3:0] d);
    int   n;
    logic acc;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    do begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    if (!acc) check("in_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || m_active || exp_q.size() != 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) check("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.wt_valid = 1'b0;
    bus.wt_first = 1'b0;
    bus.wt_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wt_ready", bus.wt_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic layer with free-running consumer
    ready_mode = 0;
    write_wt(1'b1, 8'h55);
    write_wt(1'b0, 8'hFF);
    write_wt(1'b0, 8'h00);
    write_wt(1'b0, 8'h11);
    send_in(4'hF);
    wait_idle();

    // backpressure pattern 1,0,0,1,...
    ready_mode = 1;
    rpat = 0;
    send_in(4'hF);
    wait_idle();
    ready_mode = 0;

    // simultaneous weight and input offer: weight wins
    bus.wt_valid = 1'b1;
    bus.wt_first = 1'b1;
    bus.wt_data  = 8'hC3;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hB;
    @(negedge clk);
    check("sim_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.wt_valid = 1'b0;
    bus.wt_first = 1'b0;
    send_in(4'hB);
    wait_idle();

    // weight offer during RUN is refused
    send_in(4'h7);
    bus.wt_valid = 1'b1;
    bus.wt_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    bus.wt_valid = 1'b0;
    wait_idle();
    send_in(4'hF);
    wait_idle();

    // pointer wrap and crumb decode
    do_reset();
    @(posedge clk); #1;
    write_wt(1'b0, 8'h0A);
    write_wt(1'b0, 8'h01);
    write_wt(1'b0, 8'h03);
    write_wt(1'b0, 8'h00);
    write_wt(1'b0, 8'hC0);
    send_in(4'h9);
    wait_idle();

    // reset two cycles into RUN
    write_wt(1'b1, 8'h55);
    send_in(4'hF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send_in(4'hF);
    wait_idle();

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      int nw;
      ready_mode = 2;
      nw = $urandom_range(0, 6);
      for (int j = 0; j < nw; j++)
        write_wt(1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
      send_in(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        bus.wt_valid = 1'b1;
        bus.wt_first = 1'($urandom_range(0, 1));
        bus.wt_data  = 8'($urandom_range(0, 255));
        repeat (2) @(posedge clk);
        #1;
        bus.wt_valid = 1'b0;
        bus.wt_first = 1'b0;
      end
      wait_idle();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ternary_layer_sched.md
# ternary_layer_sched

Time-multiplexed scheduler for a layer of 4-input ternary perceptrons. It stores one 8-bit ternary weight word per neuron and latches one 4-bit binary input vector. It then evaluates every neuron in turn on a single shared ternary accumulate datapath, and streams the per-neuron signed sums out over a valid/ready interface. It sits between the TinyTapeout I/O glue and the downstream result consumer, replacing one-perceptron-per-neuron replication.

## Interface
- NEURONS, default 4: neurons in the layer, legal range 2..8.
- IDX_W, default 3: width of neuron index ports; must satisfy 2^IDX_W >= NEURONS.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- wt_valid  input  1  weight word offered
- wt_first  input  1  qualifies wt_valid: this word is for neuron 0
- wt_data  input  8  ternary weights; crumb i = wt_data[2i+1:2i] weights in_data[i]
- wt_ready  output  1  weight word accepted this cycle when high with wt_valid
- in_valid  input  1  input vector offered; acceptance starts a layer evaluation
- in_data  input  4  binary inputs
- in_ready  output  1  input accepted when high with in_valid
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- out_idx  output  IDX_W  neuron index of out_data
- out_data  output  4  two's-complement neuron result
- busy  output  1  evaluation in progress (state != IDLE)

## Operation
- Crumb decode: 01 -> +1, 11 -> -1, 00 and 10 -> 0. Neuron sum = Σ w_i·in_data[i]. Range -4..+4, held in 4-bit signed, no saturation needed.
- Weight store: NEURONS x 8-bit registers, plus write pointer wptr.
  - An accepted word with wt_first writes slot 0 and sets wptr=1.
  - An accepted word without wt_first writes slot wptr and increments wptr.
  - wptr wraps from NEURONS-1 to 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: wt_ready=1. in_ready = !wt_valid, so weights win on a simultaneous offer. An accepted input latches in_data into vec, sets idx=0 and moves to RUN.
  - RUN: wt_ready=0 and in_ready=0. When the output register is free (!out_valid || out_ready), load out_data=sum(weights[idx], vec) and out_idx=idx, set out_valid=1, and increment idx. Loading idx=NEURONS-1 moves the FSM to DRAIN.
  - DRAIN: the FSM waits for out_valid && out_ready, then clears out_valid and returns to IDLE.
- Output rules:
  - out_valid/out_idx/out_data stay stable while out_valid && !out_ready.
  - In RUN, a handshake and a new load in the same cycle keep out_valid at 1.
  - In RUN, a handshake with no new load clears out_valid.
- Results are emitted in index order 0..NEURONS-1, exactly once per accepted input vector.
- Weight writes are impossible during RUN/DRAIN, so results always use one consistent weight set.
- Reset values: state=IDLE, all weight slots=0x00, wptr=0, vec=0, idx=0, out_valid=0, out_idx=0, out_data=0.
  - Combinational outputs after reset: busy=0, wt_ready=1, in_ready=!wt_valid.
- Reset mid-evaluation: rst_n low clears everything asynchronously, including out_valid, within the same cycle. No partial results are emitted after release.

## Timing
- Input accepted at edge E0: first result valid after E0+1.
- With out_ready held high, the result for neuron k is valid after edge E0+1+k.
- busy drops after edge E0+NEURONS+1.
- The next input is accepted no earlier than edge E0+NEURONS+2.
- Each cycle of out_ready low stalls the sequence by one cycle; no result is dropped or duplicated.
- A weight write takes effect at the accepting edge; an input accepted at the next edge uses the new weight.

## Configuration
- TERN_RELU_EN defined: out_data = (sum < 0) ? 0 : sum. ReLU activation is applied in the output register load; same latency.
- TERN_RELU_EN undefined: out_data is the raw signed sum.

## Test plan
- Reset, then write weights 0x55, 0xFF, 0x00, 0x11 (NEURONS=4, first word with wt_first), then input 0xF with out_ready=1.
  - Required: results (idx,data) = (0,+4), (1,-4 = 0xC), (2,0), (3,+2) on four consecutive cycles.
  - With TERN_RELU_EN defined, idx1 reads 0.
- Backpressure: same setup, out_ready toggling 1,0,0,1,...
  - Required: each result holds stable while stalled, order 0..3, exactly four handshakes, busy drops only after the last one.
- Simultaneous wt_valid=1 and in_valid=1 in IDLE.
  - Required: in_ready=0, weight is written, and the input is accepted the first cycle wt_valid is low.
- During RUN, drive wt_valid=1 with new data.
  - Required: wt_ready=0, weights unchanged, results match the pre-run weights.
- Wrap and decode: write 5 words without wt_first after reset: 0x0A, 0x01, 0x03, 0x00, 0xC0. Input 0x9.
  - The 5th word overwrites slot 0.
  - Slot 0 = 0xC0 (crumb3 = 11): result 0 = -1.
  - Slot 1 = 0x01: result 1 = +1.
  - Slot 2 = 0x03: result 2 = -1.
  - Slot 3 = 0x00: result 3 = 0.
  - 0x0A on its own (crumbs 10,10 = 0) gives 0; it is not read back because slot 0 was overwritten.
- Assert rst_n low two cycles into RUN.
  - Required: out_valid=0 immediately, busy=0 and weights=0 after release, no further results.
